paddle_step_gen: RTL and testbench

Conditions the two raw paddle push-buttons and produces the single-cycle step-enable pulses and direction that drive the 8-bit paddle position counter directly downstream (`En` here connects to that counter's enable input). It synchronises and debounces each button, resolves them to one command, emits one step per press, and auto-repeats while a button stays held. All timing is in `Clk` cycles, so simulation can use small parameter values.

---
 rtl/paddle_step_gen.sv | 140 ++++++++++++++
 tb/tb_paddle_step_gen.sv | 169 ++++++++++++++++
 2 files changed

// File: rtl/paddle_step_gen.sv
// Paddle button conditioner: synchronises and debounces two push-buttons, resolves
// them to one command and emits single-cycle step pulses with hold-to-repeat.
module paddle_step_gen #(
  parameter int DEBOUNCE_CYCLES = 1000000,
  parameter int HOLD_CYCLES     = 25000000,
  parameter int REPEAT_CYCLES   = 5000000
) (
  input  logic Clk,
  input  logic Rst,
  input  logic BtnUp,
  input  logic BtnDn,
  output logic En,
  output logic Dir,
  output logic Held
);

  localparam int DB_W   = $clog2(DEBOUNCE_CYCLES);
  localparam int T_MAX  = (HOLD_CYCLES > REPEAT_CYCLES) ? HOLD_CYCLES : REPEAT_CYCLES;
  localparam int TW     = $clog2(T_MAX);
  localparam logic [DB_W-1:0] DB_LAST     = DB_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [TW-1:0]   HOLD_LAST   = TW'(HOLD_CYCLES - 1);
  localparam logic [TW-1:0]   REPEAT_LAST = TW'(REPEAT_CYCLES - 1);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_HOLD   = 2'd1,
    ST_REPEAT = 2'd2
  } state_t;

  logic [1:0] btn_raw;
  logic [1:0] db_lvl;

  assign btn_raw = {BtnDn, BtnUp};

  // Index 0 is the up button, index 1 the down button.
  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_btn
      logic            meta_reg;
      logic            sync_reg;
      logic            db_reg;
      logic [DB_W-1:0] cnt_reg;

      always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
          meta_reg <= 1'b0;
          sync_reg <= 1'b0;
          db_reg   <= 1'b0;
          cnt_reg  <= '0;
        end else begin
          meta_reg <= btn_raw[gi];
          sync_reg <= meta_reg;
          if (sync_reg == db_reg) begin
            cnt_reg <= '0;
          end else if (cnt_reg == DB_LAST) begin
            db_reg  <= sync_reg;
            cnt_reg <= '0;
          end else begin
            cnt_reg <= cnt_reg + DB_W'(1);
          end
        end
      end

      assign db_lvl[gi] = db_reg;
    end
  endgenerate

  logic cmd_valid;
  logic cmd_up;

  // Exactly one debounced button pressed gives a command; both or neither is NONE.
  assign cmd_valid = db_lvl[0] ^ db_lvl[1];
  assign cmd_up    = db_lvl[0];

  state_t          state_reg, state_next;
  logic [TW-1:0]   timer_reg, timer_next;
  logic            en_reg, en_next;
  logic            dir_reg, dir_next;
  logic            held_reg;

  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      state_reg <= ST_IDLE;
      timer_reg <= '0;
      en_reg    <= 1'b0;
      dir_reg   <= 1'b0;
      held_reg  <= 1'b0;
    end else begin
      state_reg <= state_next;
      timer_reg <= timer_next;
      en_reg    <= en_next;
      dir_reg   <= dir_next;
      held_reg  <= (state_next == ST_REPEAT);
    end
  end

  always_comb begin
    state_next = state_reg;
    timer_next = timer_reg;
    en_next    = 1'b0;
    dir_next   = dir_reg;
    case (state_reg)
      ST_IDLE: begin
        timer_next = '0;
        if (cmd_valid) begin
          en_next    = 1'b1;
          dir_next   = cmd_up;
          state_next = ST_HOLD;
        end
      end
      ST_HOLD, ST_REPEAT: begin
        if (!cmd_valid) begin
          state_next = ST_IDLE;
          timer_next = '0;
        end else if (cmd_up != dir_reg) begin
          // Reversal restarts the hold period as a fresh press.
          en_next    = 1'b1;
          dir_next   = cmd_up;
          timer_next = '0;
          state_next = ST_HOLD;
        end else if (timer_reg == ((state_reg == ST_HOLD) ? HOLD_LAST : REPEAT_LAST)) begin
          en_next    = 1'b1;
          timer_next = '0;
          state_next = ST_REPEAT;
        end else begin
          timer_next = timer_reg + TW'(1);
        end
      end
      default: begin
        state_next = ST_IDLE;
        timer_next = '0;
      end
    endcase
  end

  assign En   = en_reg;
  assign Dir  = dir_reg;
  assign Held = held_reg;

endmodule

// File: tb/tb_paddle_step_gen.sv
// Directed bench for paddle_step_gen with DEBOUNCE=4, HOLD=8, REPEAT=3.
module tb_paddle_step_gen;

  logic Clk = 1'b0;
  logic Rst = 1'b0;
  logic BtnUp = 1'b0;
  logic BtnDn = 1'b0;
  logic En, Dir, Held;

  int n_vec = 0;
  int n_err = 0;

  logic exp_en   [0:63];
  logic exp_dir  [0:63];
  logic exp_held [0:63];

  paddle_step_gen #(
    .DEBOUNCE_CYCLES(4),
    .HOLD_CYCLES    (8),
    .REPEAT_CYCLES  (3)
  ) dut (
    .Clk  (Clk),
    .Rst  (Rst),
    .BtnUp(BtnUp),
    .BtnDn(BtnDn),
    .En   (En),
    .Dir  (Dir),
    .Held (Held)
  );

  always #5 Clk = ~Clk;

  task automatic chk(input string tag, input logic got, input logic exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %b expected %b", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge Clk);
    #1;
  endtask

  task automatic clear_exp();
    for (int i = 0; i < 64; i++) begin
      exp_en[i]   = 1'b0;
      exp_dir[i]  = 1'b0;
      exp_held[i] = 1'b0;
    end
  endtask

  task automatic pulse(input int i, input logic d);
    exp_en[i]  = 1'b1;
    exp_dir[i] = d;
  endtask

  task automatic held_span(input int a, input int b);
    for (int i = a; i <= b; i++) exp_held[i] = 1'b1;
  endtask

  // Step n edges (index i = edge k+i), checking every output each cycle;
  // buttons change to chg_val so that edge k+chg_at samples the new value.
  task automatic window(input string tag, input int n, input int chg_at, input logic [1:0] chg_val);
    for (int i = 0; i < n; i++) begin
      step();
      chk($sformatf("%s.en@%0d", tag, i), En, exp_en[i]);
      if (exp_en[i]) chk($sformatf("%s.dir@%0d", tag, i), Dir, exp_dir[i]);
      chk($sformatf("%s.held@%0d", tag, i), Held, exp_held[i]);
      if (i == chg_at - 1) {BtnDn, BtnUp} = chg_val;
    end
    $display("%s: %0d cycles checked", tag, n);
  endtask

  task automatic settle(input int n);
    BtnUp = 1'b0;
    BtnDn = 1'b0;
    for (int i = 0; i < n; i++) step();
  endtask

  initial begin
    // Reset held with buttons toggling: outputs stay low.
    for (int i = 0; i < 10; i++) begin
      step();
      {BtnDn, BtnUp} = 2'(i);
      chk($sformatf("rst.en@%0d", i), En, 1'b0);
      chk($sformatf("rst.dir@%0d", i), Dir, 1'b0);
      chk($sformatf("rst.held@%0d", i), Held, 1'b0);
    end
    BtnUp = 1'b0;
    BtnDn = 1'b0;
    step();
    Rst = 1'b1;
    clear_exp();
    window("idle", 50, 99, 2'b00);

    // Three sampled cycles of up: rejected.
    clear_exp();
    BtnUp = 1'b1;
    window("glitch", 20, 3, 2'b00);
    settle(12);

    // Single press, released before the hold expires.
    clear_exp();
    pulse(6, 1'b1);
    BtnUp = 1'b1;
    window("single", 30, 8, 2'b00);
    settle(12);

    // Down held 30 sampled cycles: auto-repeat until release debounce completes.
    clear_exp();
    pulse(6, 1'b0);
    for (int t = 14; t <= 35; t += 3) pulse(t, 1'b0);
    held_span(14, 35);
    BtnDn = 1'b1;
    window("repeat", 45, 30, 2'b00);
    settle(12);

    // Both buttons together: NONE command.
    clear_exp();
    BtnUp = 1'b1;
    BtnDn = 1'b1;
    window("conflict", 20, 12, 2'b00);
    settle(12);

    // Up into REPEAT, then swap to down: reversal pulse then fresh hold.
    clear_exp();
    pulse(6, 1'b1);
    pulse(14, 1'b1);
    pulse(17, 1'b1);
    pulse(20, 1'b1);
    pulse(22, 1'b0);
    pulse(30, 1'b0);
    pulse(33, 1'b0);
    held_span(14, 21);
    held_span(30, 33);
    BtnUp = 1'b1;
    window("reverse", 34, 16, 2'b10);
    settle(12);

    // Reset asserted mid-REPEAT, then released with up still held.
    clear_exp();
    pulse(6, 1'b1);
    pulse(14, 1'b1);
    held_span(14, 16);
    BtnUp = 1'b1;
    window("pre_rst", 17, 99, 2'b01);
    Rst = 1'b0;
    #1;
    chk("midrst.en", En, 1'b0);
    chk("midrst.held", Held, 1'b0);
    chk("midrst.dir", Dir, 1'b0);
    step();
    step();
    Rst = 1'b1;
    clear_exp();
    pulse(6, 1'b1);
    pulse(14, 1'b1);
    pulse(17, 1'b1);
    held_span(14, 19);
    window("post_rst", 20, 99, 2'b01);
    settle(12);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
